stream_to_memory: RTL and testbench
===================================

Name: stream_to_memory

Overview:
- Writeback stage. Accepts a 16-bit Avalon-ST word stream from the inference datapath and writes it to memory through a 16-bit Avalon-MM write master, at consecutive halfword addresses.
- It is the mirror of the memory-to-stream reader that feeds the datapath.
- Software programs a pointer and a word count through an Avalon-MM CSR slave, pulses go, then polls busy/done.
- An internal FIFO decouples stream backpressure from memory waitrequest.

Parameters:
- FIFO_DEPTH, 16, number of 16-bit buffer entries; must be a power of 2 and at least 2.

Ports:
- clock  in  1  single clock for all logic
- clock_sreset  in  1  synchronous, active-high reset
- s_address  in  4  CSR word address
- s_readdata  out  32  CSR read data (registered)
- s_writedata  in  32  CSR write data
- s_read  in  1  CSR read strobe
- s_write  in  1  CSR write strobe
- s_waitrequest  out  1  CSR stall
- wm_address  out  32  memory byte address
- wm_writedata  out  16  memory write data
- wm_byteenable  out  2  always 2'b11 while writing
- wm_write  out  1  memory write request
- wm_waitrequest  in  1  memory stall
- st_ready  out  1  sink ready
- st_valid  in  1  sink valid
- st_sop  in  1  start of packet (ignored except as status)
- st_eop  in  1  end of packet
- st_data  in  16  sink data

Behaviour:
- Reset values: s_readdata = 0, s_waitrequest = 0, wm_write = 0, wm_byteenable = 2'b11, wm_address = 0, wm_writedata = 0, st_ready = 0. Reset also clears busy, done, eop_err, the FIFO and all counters. Reset mid-transfer aborts immediately; no further wm_write is issued.
- CSR writes complete with no wait.
- CSR reads: s_waitrequest is high in the first cycle of s_read and low in the second. s_readdata is valid in the second cycle.
- CSR map:
  - 0: read {28'b0, eop_err, done, busy, 1'b0}; a write with bit0 = 1 is go.
  - 1: pointer, 32-bit R/W.
  - 2: word_count, bits [23:0] R/W, upper bits read 0.
  - 3: words_written, 24-bit, read-only.
- The active transfer uses copies of pointer and word_count latched on go. Later CSR writes do not affect it.
- go while busy is ignored.
- FSM states:
  - IDLE: busy = 0, st_ready = 0. On go: latch address = pointer and count = word_count, clear done, eop_err, accepted and written. If count == 0, go to FINISH; otherwise go to RUN, with busy = 1 from the next cycle.
  - RUN:
    - Stream side: st_ready = (FIFO not full) && (accepted < count). On st_valid && st_ready, push st_data and increment accepted.
    - eop_err is set if st_eop arrives on a word other than the last word (accepted == count-1), or if the last word lacks st_eop.
    - Memory side: when the FIFO is non-empty and wm_write = 0, assert wm_write with wm_writedata = FIFO head. wm_address, wm_writedata and wm_write are held stable while wm_waitrequest = 1.
    - On wm_write && !wm_waitrequest: pop the FIFO, wm_address += 2, written += 1. wm_write deasserts unless another word is available (back-to-back writes are allowed).
    - When written reaches count, go to FINISH.
  - FINISH: one cycle; set done, clear busy, return to IDLE.
- Latency: a word accepted at cycle N drives wm_write no earlier than N+1.
- Simultaneous push and pop on a full FIFO is legal. st_ready is computed from the registered full flag, so no push occurs while full.
- Counters are 24-bit. The address wraps modulo 2^32.
- Words presented after count is reached are not accepted (st_ready = 0).

Test Plan:
- pointer = 0x1000, count = 4, go; stream 4 words A0..A3 with eop on A3, no waitrequest -> writes to 0x1000/2/4/6 with A0..A3; done = 1, eop_err = 0, reg3 = 4, status read = 0x4.
- count = 20, wm_waitrequest held high for 40 cycles, stream continuous -> st_ready drops after 16 words are accepted; all 20 are written in order after release; wm_address/data are stable while stalled.
- count = 0, go -> busy never asserts, done = 1 within 2 cycles, no wm_write.
- count = 3, st_eop on word 2 of 3 -> all 3 words written, eop_err = 1.
- Mid-transfer (2 of 8 words written), assert clock_sreset -> wm_write = 0 and st_ready = 0 the next cycle; status reads 0 after reset.
- go while busy and a pointer write while busy -> the active transfer is unchanged; the next go uses the new pointer.

Source files
------------

// File: rtl/stream_to_memory.sv
// rtl/stream_to_memory.sv - Avalon-ST to Avalon-MM halfword writeback engine with CSR slave
// A FIFO decouples stream backpressure from memory waitrequest; transfers run from latched pointer/count.
module stream_to_memory #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clock,
    input  logic        clock_sreset,
    input  logic [3:0]  s_address,
    output logic [31:0] s_readdata,
    input  logic [31:0] s_writedata,
    input  logic        s_read,
    input  logic        s_write,
    output logic        s_waitrequest,
    output logic [31:0] wm_address,
    output logic [15:0] wm_writedata,
    output logic [1:0]  wm_byteenable,
    output logic        wm_write,
    input  logic        wm_waitrequest,
    output logic        st_ready,
    input  logic        st_valid,
    input  logic        st_sop,
    input  logic        st_eop,
    input  logic [15:0] st_data
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [31:0]   r_pointer;
    logic [23:0]   r_word_count;
    logic [23:0]   r_count;
    logic [23:0]   r_accepted;
    logic [23:0]   r_written;
    logic [31:0]   r_wm_address;
    logic [15:0]   r_wm_writedata;
    logic          r_wm_write;
    logic          r_done;
    logic          r_eop_err;
    logic          r_full;
    logic          r_rd_phase;
    logic [31:0]   r_readdata;
    logic [15:0]   r_fifo [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_fifo_cnt;

    logic          w_go;
    logic          w_start;
    logic          w_busy;
    logic          w_st_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_load;
    logic          w_last_word;
    logic          w_last_write;
    logic [AW:0]   w_fifo_cnt_nxt;
    logic [AW-1:0] w_head_ptr;
    logic [31:0]   w_rd_mux;
    logic          w_unused;

    assign w_unused       = st_sop;
    assign w_go           = s_write && (s_address == 4'd0) && s_writedata[0];
    assign w_start        = w_go && (r_state == S_IDLE);
    assign w_push         = st_valid && w_st_ready;
    assign w_pop          = r_wm_write && !wm_waitrequest;
    assign w_last_word    = (r_accepted == r_count - 24'd1);
    assign w_last_write   = (r_written + 24'd1 == r_count);
    assign w_fifo_cnt_nxt = r_fifo_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    // While a write is outstanding its word is still the FIFO head, so the next word sits one behind.
    assign w_head_ptr     = r_wm_write ? r_rd_ptr + AW'(1) : r_rd_ptr;
    assign w_load         = (r_state == S_RUN) &&
                            ((!r_wm_write && (r_fifo_cnt != '0)) ||
                             (w_pop && (r_fifo_cnt > (AW+1)'(1))));

    always_comb begin
        w_state_nxt = r_state;
        w_st_ready  = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    w_state_nxt = (r_word_count == 24'd0) ? S_FINISH : S_RUN;
                end
            end
            S_RUN: begin
                w_busy     = 1'b1;
                w_st_ready = !r_full && (r_accepted < r_count);
                if (w_pop && w_last_write) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_rd_mux = 32'd0;
        case (s_address)
            4'd0:    w_rd_mux = {28'd0, r_eop_err, r_done, w_busy, 1'b0};
            4'd1:    w_rd_mux = r_pointer;
            4'd2:    w_rd_mux = {8'd0, r_word_count};
            4'd3:    w_rd_mux = {8'd0, r_written};
            default: w_rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= st_data;
        end
    end

    always_ff @(posedge clock) begin
        if (clock_sreset) begin
            r_state        <= S_IDLE;
            r_pointer      <= 32'd0;
            r_word_count   <= 24'd0;
            r_count        <= 24'd0;
            r_accepted     <= 24'd0;
            r_written      <= 24'd0;
            r_wm_address   <= 32'd0;
            r_wm_writedata <= 16'd0;
            r_wm_write     <= 1'b0;
            r_done         <= 1'b0;
            r_eop_err      <= 1'b0;
            r_full         <= 1'b0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_fifo_cnt     <= '0;
            r_rd_phase     <= 1'b0;
            r_readdata     <= 32'd0;
        end else begin
            r_state <= w_state_nxt;

            if (s_write) begin
                case (s_address)
                    4'd1:    r_pointer    <= s_writedata;
                    4'd2:    r_word_count <= s_writedata[23:0];
                    default: ;
                endcase
            end

            if (w_start) begin
                r_wm_address <= r_pointer;
                r_count      <= r_word_count;
                r_done       <= 1'b0;
                r_eop_err    <= 1'b0;
                r_accepted   <= 24'd0;
                r_written    <= 24'd0;
                r_wr_ptr     <= '0;
                r_rd_ptr     <= '0;
                r_fifo_cnt   <= '0;
                r_full       <= 1'b0;
                r_wm_write   <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr   <= r_wr_ptr + AW'(1);
                    r_accepted <= r_accepted + 24'd1;
                    // eop must appear exactly on the final word of the transfer.
                    if (st_eop != w_last_word) begin
                        r_eop_err <= 1'b1;
                    end
                end
                if (w_pop) begin
                    r_rd_ptr     <= r_rd_ptr + AW'(1);
                    r_wm_address <= r_wm_address + 32'd2;
                    r_written    <= r_written + 24'd1;
                end
                r_fifo_cnt <= w_fifo_cnt_nxt;
                r_full     <= (w_fifo_cnt_nxt == FULL_CNT);
                if (w_load) begin
                    r_wm_write     <= 1'b1;
                    r_wm_writedata <= r_fifo[w_head_ptr];
                end else if (w_pop) begin
                    r_wm_write <= 1'b0;
                end
                if (r_state == S_FINISH) begin
                    r_done <= 1'b1;
                end
            end

            if (r_rd_phase) begin
                r_rd_phase <= 1'b0;
            end else if (s_read) begin
                r_rd_phase <= 1'b1;
                r_readdata <= w_rd_mux;
            end
        end
    end

    assign s_waitrequest = s_read && !r_rd_phase;
    assign s_readdata    = r_readdata;
    assign wm_address    = r_wm_address;
    assign wm_writedata  = r_wm_writedata;
    assign wm_write      = r_wm_write;
    assign wm_byteenable = 2'b11;
    assign st_ready      = w_st_ready;

endmodule

// File: tb/tb_stream_to_memory.sv
// tb/tb_stream_to_memory.sv - scoreboard bench for stream_to_memory
module tb_stream_to_memory;

    logic        clock = 1'b0;
    logic        clock_sreset = 1'b1;
    logic [3:0]  s_address = 4'd0;
    logic [31:0] s_readdata;
    logic [31:0] s_writedata = 32'd0;
    logic        s_read = 1'b0;
    logic        s_write = 1'b0;
    logic        s_waitrequest;
    logic [31:0] wm_address;
    logic [15:0] wm_writedata;
    logic [1:0]  wm_byteenable;
    logic        wm_write;
    logic        wm_waitrequest = 1'b0;
    logic        st_ready;
    logic        st_valid = 1'b0;
    logic        st_sop = 1'b0;
    logic        st_eop = 1'b0;
    logic [15:0] st_data = 16'd0;

    stream_to_memory #(.FIFO_DEPTH(16)) dut (
        .clock          (clock),
        .clock_sreset   (clock_sreset),
        .s_address      (s_address),
        .s_readdata     (s_readdata),
        .s_writedata    (s_writedata),
        .s_read         (s_read),
        .s_write        (s_write),
        .s_waitrequest  (s_waitrequest),
        .wm_address     (wm_address),
        .wm_writedata   (wm_writedata),
        .wm_byteenable  (wm_byteenable),
        .wm_write       (wm_write),
        .wm_waitrequest (wm_waitrequest),
        .st_ready       (st_ready),
        .st_valid       (st_valid),
        .st_sop         (st_sop),
        .st_eop         (st_eop),
        .st_data        (st_data)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] data;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    wr_t         sb_q[$];
    wr_t         e;
    logic [31:0] exp_base = 32'd0;
    int          acc_idx = 0;
    int          wr_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    logic [15:0] prev_data = 16'd0;

    // Expected writes are queued as the stream side hands words over and retired as memory accepts them.
    always @(negedge clock) begin
        if (clock_sreset) begin
            sb_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (st_valid && st_ready) begin
                e.addr = exp_base + 32'(2 * acc_idx);
                e.data = st_data;
                sb_q.push_back(e);
                acc_idx++;
            end
            if (prev_stall) begin
                checks++;
                if (wm_write !== 1'b1 || wm_address !== prev_addr || wm_writedata !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold: wm_write=%0b addr=%h data=%h, required 1 addr=%h data=%h",
                             wm_write, wm_address, wm_writedata, prev_addr, prev_data);
                end
            end
            if (wm_write && !wm_waitrequest) begin
                checks++;
                wr_cnt++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr=%h data=%h, required no write", wm_address, wm_writedata);
                end else begin
                    e = sb_q.pop_front();
                    if (wm_address !== e.addr || wm_writedata !== e.data || wm_byteenable !== 2'b11) begin
                        errors++;
                        $display("FAIL mem_write: addr=%h data=%h be=%b, required addr=%h data=%h be=11",
                                 wm_address, wm_writedata, wm_byteenable, e.addr, e.data);
                    end
                end
            end
            prev_stall = wm_write && wm_waitrequest;
            prev_addr  = wm_address;
            prev_data  = wm_writedata;
        end
    end

    task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
        @(posedge clock); #1;
        s_address = a; s_writedata = d; s_write = 1'b1;
        @(posedge clock); #1;
        s_write = 1'b0;
    endtask

    task automatic csr_read(input logic [3:0] a, output logic [31:0] d);
        @(posedge clock); #1;
        s_address = a; s_read = 1'b1;
        @(posedge clock); #1;
        d = s_readdata;
        @(posedge clock); #1;
        s_read = 1'b0;
    endtask

    task automatic wait_done(output logic [31:0] st);
        st = 32'd0;
        for (int i = 0; i < 300; i++) begin
            csr_read(4'd0, st);
            if (st[2] && !st[1]) return;
        end
        checks++; errors++;
        $display("FAIL done_timeout: status=%h, required done=1 busy=0", st);
    endtask

    task automatic start_xfer(input logic [31:0] ptr, input logic [31:0] cnt);
        exp_base = ptr;
        acc_idx  = 0;
        csr_write(4'd1, ptr);
        csr_write(4'd2, cnt);
        csr_write(4'd0, 32'd1);
    endtask

    task automatic drive_stream(input int n, input int eop_idx, input logic [15:0] dbase);
        for (int i = 0; i < n; i++) begin
            int t;
            bit taken;
            t = 0;
            taken = 1'b0;
            st_valid = 1'b1;
            st_data  = dbase + 16'(i);
            st_eop   = (i == eop_idx);
            st_sop   = (i == 0);
            while (!taken) begin
                @(negedge clock);
                if (st_ready) taken = 1'b1;
                @(posedge clock); #1;
                t++;
                if (!taken && t > 400) begin
                    checks++; errors++;
                    $display("FAIL stream_timeout: word %0d not accepted, required st_ready", i);
                    st_valid = 1'b0; st_eop = 1'b0; st_sop = 1'b0;
                    return;
                end
            end
        end
        st_valid = 1'b0; st_eop = 1'b0; st_sop = 1'b0;
    endtask

    task automatic test_reset();
        clock_sreset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (wm_write !== 1'b0) begin errors++; $display("FAIL rst_wm_write: got %b, required 0", wm_write); end
        checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL rst_st_ready: got %b, required 0", st_ready); end
        checks++; if (wm_address !== 32'd0) begin errors++; $display("FAIL rst_wm_address: got %h, required 0", wm_address); end
        checks++; if (wm_writedata !== 16'd0) begin errors++; $display("FAIL rst_wm_writedata: got %h, required 0", wm_writedata); end
        checks++; if (wm_byteenable !== 2'b11) begin errors++; $display("FAIL rst_byteenable: got %b, required 11", wm_byteenable); end
        checks++; if (s_waitrequest !== 1'b0) begin errors++; $display("FAIL rst_s_waitrequest: got %b, required 0", s_waitrequest); end
        checks++; if (s_readdata !== 32'd0) begin errors++; $display("FAIL rst_s_readdata: got %h, required 0", s_readdata); end
        clock_sreset = 1'b0;
        @(posedge clock); #1;
        s_address = 4'd0; s_read = 1'b1;
        #1;
        checks++; if (s_waitrequest !== 1'b1) begin errors++; $display("FAIL rd_wait_first: got %b, required 1", s_waitrequest); end
        @(posedge clock); #1;
        checks++; if (s_waitrequest !== 1'b0) begin errors++; $display("FAIL rd_wait_second: got %b, required 0", s_waitrequest); end
        checks++; if (s_readdata !== 32'd0) begin errors++; $display("FAIL rst_status: got %h, required 0", s_readdata); end
        @(posedge clock); #1;
        s_read = 1'b0;
    endtask

    task automatic test_zero_count();
        logic [31:0] st;
        int w0;
        w0 = wr_cnt;
        csr_write(4'd2, 32'd0);
        csr_write(4'd0, 32'd1);
        csr_read(4'd0, st);
        checks++; if (st !== 32'h4) begin errors++; $display("FAIL zero_status: got %h, required 4", st); end
        repeat (5) @(posedge clock);
        #1;
        checks++; if (wr_cnt != w0) begin errors++; $display("FAIL zero_writes: got %0d, required 0", wr_cnt - w0); end
    endtask

    task automatic test_basic();
        logic [31:0] st, r3;
        int w0;
        w0 = wr_cnt;
        start_xfer(32'h1000, 32'd4);
        drive_stream(4, 3, 16'hA0);
        wait_done(st);
        checks++; if (st !== 32'h4) begin errors++; $display("FAIL basic_status: got %h, required 4", st); end
        csr_read(4'd3, r3);
        checks++; if (r3 !== 32'd4) begin errors++; $display("FAIL basic_written: got %0d, required 4", r3); end
        checks++; if (wr_cnt - w0 != 4 || sb_q.size() != 0) begin
            errors++; $display("FAIL basic_count: writes=%0d pending=%0d, required 4 and 0", wr_cnt - w0, sb_q.size());
        end
    endtask

    task automatic test_stall();
        logic [31:0] st, r3;
        int w0;
        w0 = wr_cnt;
        wm_waitrequest = 1'b1;
        start_xfer(32'h4000, 32'd20);
        fork
            drive_stream(20, 19, 16'h4000);
            begin
                repeat (40) @(posedge clock);
                #2;
                checks++; if (acc_idx != 16) begin errors++; $display("FAIL stall_accepted: got %0d, required 16", acc_idx); end
                checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b, required 0", st_ready); end
                checks++; if (wm_write !== 1'b1 || wr_cnt != w0) begin
                    errors++; $display("FAIL stall_write: wm_write=%b writes=%0d, required 1 and 0", wm_write, wr_cnt - w0);
                end
                wm_waitrequest = 1'b0;
            end
        join
        wait_done(st);
        checks++; if (st !== 32'h4) begin errors++; $display("FAIL stall_status: got %h, required 4", st); end
        csr_read(4'd3, r3);
        checks++; if (r3 !== 32'd20) begin errors++; $display("FAIL stall_written: got %0d, required 20", r3); end
        checks++; if (wr_cnt - w0 != 20 || sb_q.size() != 0) begin
            errors++; $display("FAIL stall_count: writes=%0d pending=%0d, required 20 and 0", wr_cnt - w0, sb_q.size());
        end
    endtask

    task automatic test_eop_err();
        logic [31:0] st, r3;
        int w0;
        w0 = wr_cnt;
        start_xfer(32'h6000, 32'd3);
        drive_stream(3, 1, 16'h6000);
        wait_done(st);
        checks++; if (st !== 32'hC) begin errors++; $display("FAIL eop_status: got %h, required c", st); end
        csr_read(4'd3, r3);
        checks++; if (r3 !== 32'd3) begin errors++; $display("FAIL eop_written: got %0d, required 3", r3); end
        checks++; if (wr_cnt - w0 != 3) begin errors++; $display("FAIL eop_count: got %0d, required 3", wr_cnt - w0); end
    endtask

    task automatic test_go_while_busy();
        logic [31:0] st, r;
        int w0;
        w0 = wr_cnt;
        wm_waitrequest = 1'b1;
        start_xfer(32'h2000, 32'd4);
        csr_write(4'd1, 32'h3000);
        csr_write(4'd0, 32'd1);
        drive_stream(4, 3, 16'h2000);
        csr_read(4'd0, st);
        checks++; if (st !== 32'h2) begin errors++; $display("FAIL busy_status: got %h, required 2", st); end
        wm_waitrequest = 1'b0;
        wait_done(st);
        checks++; if (st !== 32'h4) begin errors++; $display("FAIL busy_done: got %h, required 4", st); end
        csr_read(4'd3, r);
        checks++; if (r !== 32'd4) begin errors++; $display("FAIL busy_written: got %0d, required 4", r); end
        csr_read(4'd1, r);
        checks++; if (r !== 32'h3000) begin errors++; $display("FAIL busy_pointer: got %h, required 3000", r); end
        exp_base = 32'h3000;
        acc_idx  = 0;
        csr_write(4'd0, 32'd1);
        drive_stream(4, 3, 16'h3000);
        wait_done(st);
        checks++; if (wr_cnt - w0 != 8 || sb_q.size() != 0) begin
            errors++; $display("FAIL busy_count: writes=%0d pending=%0d, required 8 and 0", wr_cnt - w0, sb_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        int w0, t;
        w0 = wr_cnt;
        start_xfer(32'h5000, 32'd8);
        drive_stream(2, -1, 16'h5000);
        t = 0;
        while (wr_cnt - w0 < 2 && t < 50) begin
            @(posedge clock);
            t++;
        end
        #1;
        checks++; if (wr_cnt - w0 != 2) begin errors++; $display("FAIL mid_pre_writes: got %0d, required 2", wr_cnt - w0); end
        wm_waitrequest = 1'b1;
        drive_stream(1, -1, 16'h5002);
        repeat (2) @(posedge clock);
        #1;
        checks++; if (wm_write !== 1'b1) begin errors++; $display("FAIL mid_pending: got %b, required 1", wm_write); end
        clock_sreset = 1'b1;
        @(posedge clock); #1;
        checks++; if (wm_write !== 1'b0) begin errors++; $display("FAIL mid_wm_write: got %b, required 0", wm_write); end
        checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL mid_st_ready: got %b, required 0", st_ready); end
        clock_sreset = 1'b0;
        wm_waitrequest = 1'b0;
        csr_read(4'd0, r);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL mid_status: got %h, required 0", r); end
        csr_read(4'd3, r);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL mid_written: got %0d, required 0", r); end
        csr_read(4'd1, r);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL mid_pointer: got %h, required 0", r); end
        checks++; if (wr_cnt - w0 != 2) begin errors++; $display("FAIL mid_post_writes: got %0d, required 2", wr_cnt - w0); end
    endtask

    initial begin
        test_reset();
        test_zero_count();
        test_basic();
        test_stall();
        test_eop_err();
        test_go_while_busy();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
